xbus_pad_arb: RTL and testbench

- Parametrised successor to the flat per-pin pad split.
- Arbitrates CH internal requesters onto one shared bidirectional pad bus (xd/xa/xma style), drives registered `_out`/`_oe` pad pins and enforces bus-turnaround dead cycles between owners.
- Samples `_in` pins through a configurable synchroniser and returns read data.
- Sits between the chip core and the top-level pad split.

---
 rtl/xbus_pad_arb.sv | 188 ++++++++++++++++++
 tb/tb_xbus_pad_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbus_pad_arb.sv
// Priority arbiter driving a shared bidirectional pad bus with turnaround dead cycles and a
// synchronised input path. Optional loopback contention check: define XBUS_LOOPBACK_CHK_EN.
module xbus_pad_arb #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned CH        = 4,
    parameter int unsigned TURN_CYC  = 1,
    parameter int unsigned IN_STAGES = 2
) (
    input  logic                           i_sys_clk,
    input  logic                           i_reset,
    input  logic [CH-1:0]                  i_req,
    input  logic [CH*WIDTH-1:0]            i_wdata,
    input  logic [CH*(WIDTH/LANE_W)-1:0]   i_lane_en,
    output logic [CH-1:0]                  o_gnt,
    output logic [WIDTH-1:0]               o_pad_out,
    output logic [WIDTH-1:0]               o_pad_oe,
    input  logic [WIDTH-1:0]               i_pad_in,
    output logic [WIDTH-1:0]               o_rdata,
    output logic                           o_rd_ext,
    output logic                           o_busy,
    output logic                           o_err
);

    localparam int unsigned NL = WIDTH / LANE_W;
    localparam int unsigned OW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {StIdle, StDrive, StTurn} state_t;

    state_t            r_state, w_state_nxt;
    logic [OW-1:0]     r_owner, w_owner_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [CH-1:0]     r_gnt, w_gnt_nxt;
    logic [WIDTH-1:0]  r_pad_out, w_pad_out_nxt;
    logic [WIDTH-1:0]  r_pad_oe, w_pad_oe_nxt;

    logic              w_win_vld;
    logic [OW-1:0]     w_win;
    logic              w_arb;
    logic [WIDTH-1:0]  w_win_data, w_own_data;
    logic [NL-1:0]     w_win_lanes, w_own_lanes;

    function automatic logic [WIDTH-1:0] f_expand(input logic [NL-1:0] lanes);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int l = 0; l < int'(NL); l++) begin
            v[l*LANE_W +: LANE_W] = {LANE_W{lanes[l]}};
        end
        return v;
    endfunction

    // Lowest set request index wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win     = '0;
        for (int k = int'(CH) - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                w_win_vld = 1'b1;
                w_win     = OW'(k);
            end
        end
    end

    assign w_win_data  = i_wdata[int'(w_win)*WIDTH +: WIDTH];
    assign w_win_lanes = i_lane_en[int'(w_win)*NL +: NL];
    assign w_own_data  = i_wdata[int'(r_owner)*WIDTH +: WIDTH];
    assign w_own_lanes = i_lane_en[int'(r_owner)*NL +: NL];

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        w_pad_out_nxt = r_pad_out;
        w_pad_oe_nxt  = r_pad_oe;
        w_arb         = 1'b0;
        unique case (r_state)
            StIdle: w_arb = 1'b1;
            StDrive: begin
                if (i_req[r_owner]) begin
                    w_pad_out_nxt = w_own_data;
                    w_pad_oe_nxt  = f_expand(w_own_lanes);
                end else begin
                    // Release: pad_out keeps its last value, only oe and grant drop.
                    w_gnt_nxt    = '0;
                    w_pad_oe_nxt = '0;
                    if (TURN_CYC > 0) begin
                        w_state_nxt = StTurn;
                        w_cnt_nxt   = 4'(TURN_CYC - 1);
                    end else begin
                        w_arb = 1'b1;
                    end
                end
            end
            StTurn: begin
                if (r_cnt == '0) w_arb = 1'b1;
                else             w_cnt_nxt = r_cnt - 4'd1;
            end
            default: w_state_nxt = StIdle;
        endcase
        if (w_arb) begin
            if (w_win_vld) begin
                w_state_nxt   = StDrive;
                w_owner_nxt   = w_win;
                w_gnt_nxt     = CH'(1) << w_win;
                w_pad_out_nxt = w_win_data;
                w_pad_oe_nxt  = f_expand(w_win_lanes);
            end else begin
                w_state_nxt  = StIdle;
                w_gnt_nxt    = '0;
                w_pad_oe_nxt = '0;
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_pad_out <= '0;
            r_pad_oe  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_pad_out <= w_pad_out_nxt;
            r_pad_oe  <= w_pad_oe_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_pad_out = r_pad_out;
    assign o_pad_oe  = r_pad_oe;
    assign o_busy    = (r_state != StIdle);

    // Input synchroniser; r_ext tracks "bus undriven" alongside each sample.
    logic [WIDTH-1:0]     r_in [IN_STAGES];
    logic [IN_STAGES-1:0] r_ext;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            for (int s = 0; s < int'(IN_STAGES); s++) r_in[s] <= '0;
            r_ext <= '0;
        end else begin
            r_in[0]  <= i_pad_in;
            r_ext[0] <= ~|r_pad_oe;
            for (int s = 1; s < int'(IN_STAGES); s++) begin
                r_in[s]  <= r_in[s-1];
                r_ext[s] <= r_ext[s-1];
            end
        end
    end

    assign o_rdata  = r_in[IN_STAGES-1];
    assign o_rd_ext = r_ext[IN_STAGES-1];

`ifdef XBUS_LOOPBACK_CHK_EN
    logic [WIDTH-1:0] r_lb_out [IN_STAGES];
    logic [WIDTH-1:0] r_lb_oe  [IN_STAGES];
    logic             r_err;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            for (int s = 0; s < int'(IN_STAGES); s++) begin
                r_lb_out[s] <= '0;
                r_lb_oe[s]  <= '0;
            end
            r_err <= 1'b0;
        end else begin
            r_lb_out[0] <= r_pad_out;
            r_lb_oe[0]  <= r_pad_oe;
            for (int s = 1; s < int'(IN_STAGES); s++) begin
                r_lb_out[s] <= r_lb_out[s-1];
                r_lb_oe[s]  <= r_lb_oe[s-1];
            end
            if (|((o_rdata ^ r_lb_out[IN_STAGES-1]) & r_lb_oe[IN_STAGES-1])) r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_xbus_pad_arb.sv
// Bench for xbus_pad_arb: three instances (TURN_CYC 1, 3, 0) share stimulus and are checked
// every cycle against a behavioural bus model, plus literal directed expectations.
module tb_xbus_pad_arb;

    localparam int NI = 3;
    localparam int IS = 2;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [255:0] wdata;
    logic [31:0]  lane;
    logic [63:0]  pin;

    logic [3:0]  gnt_w  [NI];
    logic [63:0] out_w  [NI];
    logic [63:0] oe_w   [NI];
    logic [63:0] rd_w   [NI];
    logic        ext_w  [NI];
    logic        busy_w [NI];
    logic        err_w  [NI];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

`ifdef XBUS_LOOPBACK_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    for (genvar g = 0; g < NI; g++) begin : g_dut
        xbus_pad_arb #(
            .WIDTH    (64),
            .LANE_W   (8),
            .CH       (4),
            .TURN_CYC ((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
            .IN_STAGES(IS)
        ) u_dut (
            .i_sys_clk(clk),
            .i_reset  (rst),
            .i_req    (req),
            .i_wdata  (wdata),
            .i_lane_en(lane),
            .o_gnt    (gnt_w[g]),
            .o_pad_out(out_w[g]),
            .o_pad_oe (oe_w[g]),
            .i_pad_in (pin),
            .o_rdata  (rd_w[g]),
            .o_rd_ext (ext_w[g]),
            .o_busy   (busy_w[g]),
            .o_err    (err_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int tc(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
    endfunction

    // Behavioural model: owner (-1 = none) and remaining dead cycles after a release.
    int          m_own  [NI];
    int          m_dead [NI];
    logic [3:0]  m_gnt  [NI];
    logic [63:0] m_out  [NI];
    logic [63:0] m_oe   [NI];
    logic        m_err  [NI];
    logic [63:0] m_qin  [NI][IS];
    logic        m_qz   [NI][IS];
    logic [63:0] m_qo   [NI][IS];
    logic [63:0] m_qe   [NI][IS];

    function automatic logic [63:0] lanes_to_bits(input logic [7:0] l);
        logic [63:0] v = '0;
        for (int b = 0; b < 8; b++) if (l[b]) v[b*8 +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic m_arb(input int i);
        m_own[i] = -1;
        for (int k = 0; k < 4; k++) begin
            if (req[k]) begin
                m_own[i] = k;
                break;
            end
        end
        if (m_own[i] >= 0) begin
            m_gnt[i] = 4'(1 << m_own[i]);
            m_out[i] = wdata[m_own[i]*64 +: 64];
            m_oe[i]  = lanes_to_bits(lane[m_own[i]*8 +: 8]);
        end else begin
            m_gnt[i] = '0;
            m_oe[i]  = '0;
        end
    endtask

    task automatic m_step(input int i);
        if (rst) begin
            m_own[i] = -1; m_dead[i] = 0; m_gnt[i] = '0; m_out[i] = '0; m_oe[i] = '0;
            m_err[i] = 1'b0;
            for (int s = 0; s < IS; s++) begin
                m_qin[i][s] = '0; m_qz[i][s] = 1'b0; m_qo[i][s] = '0; m_qe[i][s] = '0;
            end
        end else begin
`ifdef XBUS_LOOPBACK_CHK_EN
            if (((m_qin[i][0] ^ m_qo[i][0]) & m_qe[i][0]) != 0) m_err[i] = 1'b1;
`endif
            for (int s = 0; s < IS - 1; s++) begin
                m_qin[i][s] = m_qin[i][s+1]; m_qz[i][s] = m_qz[i][s+1];
                m_qo[i][s]  = m_qo[i][s+1];  m_qe[i][s] = m_qe[i][s+1];
            end
            m_qin[i][IS-1] = pin;
            m_qz[i][IS-1]  = (m_oe[i] == 0);
            m_qo[i][IS-1]  = m_out[i];
            m_qe[i][IS-1]  = m_oe[i];
            if (m_own[i] >= 0) begin
                if (req[m_own[i]]) begin
                    m_out[i] = wdata[m_own[i]*64 +: 64];
                    m_oe[i]  = lanes_to_bits(lane[m_own[i]*8 +: 8]);
                end else begin
                    m_gnt[i] = '0;
                    m_oe[i]  = '0;
                    if (tc(i) > 0) begin
                        m_own[i]  = -1;
                        m_dead[i] = tc(i);
                    end else begin
                        m_arb(i);
                    end
                end
            end else if (m_dead[i] > 1) begin
                m_dead[i]--;
            end else begin
                m_dead[i] = 0;
                m_arb(i);
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) m_step(i);
    end

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] actual=%h required=%h at %0t", nm, i, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk("gnt", i, 64'(gnt_w[i]), 64'(m_gnt[i]));
                chk("pad_out", i, out_w[i], m_out[i]);
                chk("pad_oe", i, oe_w[i], m_oe[i]);
                chk("rdata", i, rd_w[i], m_qin[i][0]);
                chk("rd_ext", i, 64'(ext_w[i]), 64'(m_qz[i][0]));
                chk("busy", i, 64'(busy_w[i]), 64'((m_own[i] >= 0) || (m_dead[i] > 0)));
                chk("err", i, 64'(err_w[i]), 64'(m_err[i]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; req = '0; wdata = '0; lane = '0; pin = '0;
        repeat (3) cyc();
        chk_en = 1'b1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_gnt", i, 64'(gnt_w[i]), 64'h0);
            chk("rst_oe", i, oe_w[i], 64'h0);
            chk("rst_busy", i, 64'(busy_w[i]), 64'h0);
            chk("rst_rdata", i, rd_w[i], 64'h0);
        end
        rst = 1'b0;

        // Single request on channel 2.
        wdata[2*64 +: 64] = 64'h1122334455667788;
        lane[2*8 +: 8]    = 8'hFF;
        req = 4'b0100;
        cyc();
        for (int i = 0; i < NI; i++) begin
            chk("single_gnt", i, 64'(gnt_w[i]), 64'h4);
            chk("single_out", i, out_w[i], 64'h1122334455667788);
            chk("single_oe", i, oe_w[i], 64'hFFFF_FFFF_FFFF_FFFF);
        end
        req = '0;
        repeat (6) cyc();

        // Priority: 1 beats 3, and 3 waits while 1 holds.
        wdata[1*64 +: 64] = 64'hCAFE_F00D_DEAD_BEEF;
        wdata[3*64 +: 64] = 64'h0F0F_0F0F_1234_5678;
        lane[1*8 +: 8]    = 8'hFF;
        lane[3*8 +: 8]    = 8'hFF;
        req = 4'b1010;
        cyc();
        for (int i = 0; i < NI; i++) chk("prio_gnt", i, 64'(gnt_w[i]), 64'h2);
        repeat (3) begin
            cyc();
            for (int i = 0; i < NI; i++) chk("prio_hold", i, 64'(gnt_w[i]), 64'h2);
        end

        // Turnaround: owner 1 releases at u while 3 waits.
        req = 4'b1000;
        cyc();  // u+1
        chk("turn3_gnt_u1", 1, 64'(gnt_w[1]), 64'h0);
        chk("turn3_oe_u1", 1, oe_w[1], 64'h0);
        chk("turn1_gnt_u1", 0, 64'(gnt_w[0]), 64'h0);
        chk("turn0_gnt_u1", 2, 64'(gnt_w[2]), 64'h8);
        cyc();  // u+2
        chk("turn3_gnt_u2", 1, 64'(gnt_w[1]), 64'h0);
        chk("turn3_oe_u2", 1, oe_w[1], 64'h0);
        chk("turn1_gnt_u2", 0, 64'(gnt_w[0]), 64'h8);
        cyc();  // u+3
        chk("turn3_gnt_u3", 1, 64'(gnt_w[1]), 64'h0);
        chk("turn3_oe_u3", 1, oe_w[1], 64'h0);
        cyc();  // u+4
        chk("turn3_gnt_u4", 1, 64'(gnt_w[1]), 64'h8);

        // Partial lanes, then no lanes while still owning the bus.
        lane[3*8 +: 8] = 8'h0F;
        cyc();
        for (int i = 0; i < NI; i++) chk("lanes_0f", i, oe_w[i], 64'h0000_0000_FFFF_FFFF);
        lane[3*8 +: 8] = 8'h00;
        cyc();
        for (int i = 0; i < NI; i++) begin
            chk("lanes_00_oe", i, oe_w[i], 64'h0);
            chk("lanes_00_gnt", i, 64'(gnt_w[i]), 64'h8);
        end
        req = '0;
        repeat (6) cyc();

        // Input latency with the bus idle.
        pin = {8{8'hA5}};
        cyc();
        pin = '0;
        cyc();
        for (int i = 0; i < NI; i++) begin
            chk("in_rdata", i, rd_w[i], {8{8'hA5}});
            chk("in_rd_ext", i, 64'(ext_w[i]), 64'h1);
        end

        // Driving: rd_ext falls two cycles after oe rises.
        wdata[0 +: 64] = 64'h0123_4567_89AB_CDEF;
        lane[0 +: 8]   = 8'hFF;
        pin = 64'h0123_4567_89AB_CDEF;
        req = 4'b0001;
        cyc();
        for (int i = 0; i < NI; i++) chk("drv_oe", i, oe_w[i], 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();
        cyc();
        for (int i = 0; i < NI; i++) chk("drv_rd_ext", i, 64'(ext_w[i]), 64'h0);

        // Reset mid-drive with req still held.
        rst = 1'b1;
        cyc();
        for (int i = 0; i < NI; i++) begin
            chk("mid_rst_gnt", i, 64'(gnt_w[i]), 64'h0);
            chk("mid_rst_oe", i, oe_w[i], 64'h0);
            chk("mid_rst_busy", i, 64'(busy_w[i]), 64'h0);
        end
        rst = 1'b0;
        pin = 64'h0123_4567_89AB_CDEE;  // bit 0 inverted against the driven value
        cyc();  // c: oe rises again
        for (int i = 0; i < NI; i++) chk("lb_oe", i, oe_w[i], 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();
        cyc();  // c+2
        for (int i = 0; i < NI; i++) chk("lb_err_early", i, 64'(err_w[i]), 64'h0);
        cyc();  // c+3
        for (int i = 0; i < NI; i++) chk("lb_err", i, 64'(err_w[i]), 64'(EXP_ERR));
        pin = 64'h0123_4567_89AB_CDEF;
        cyc();
        cyc();
        for (int i = 0; i < NI; i++) chk("lb_err_hold", i, 64'(err_w[i]), 64'(EXP_ERR));

        // Randomized traffic.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                wdata[k*64 +: 64] = {$urandom, $urandom};
                lane[k*8 +: 8]    = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            end
            pin = ($urandom_range(0, 7) != 0) ? m_out[0] : {$urandom, $urandom};
            cyc();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
